// File: rtl/secded_pkg.sv
// secded_pkg: shared constants, types and Hamming(12,8)+overall-parity helpers.
//   DATA_W / CODE_W  : data and codeword widths
//   status_e         : response status codes (clean / corrected / uncorrectable)
//   ctrl_state_e     : controller FSM states
//   DATA_POS         : Hamming position of each data bit d0..d7
//   encode/syndrome/extract : codeword helpers used by controller and decoder
package secded_pkg;

   localparam int DATA_W = 8;
   localparam int CODE_W = 13;

   typedef enum logic [1:0] {
      ST_CLEAN  = 2'b00,
      ST_CORR   = 2'b01,
      ST_UNCORR = 2'b10
   } status_e;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WR   = 3'd1,
      RD   = 3'd2,
      WB   = 3'd3,
      RSP  = 3'd4
   } ctrl_state_e;

   localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12};

   // Check bit 2^k covers every position whose index has bit k set.
   function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
      logic [CODE_W-1:0] cw;
      logic              par;
      cw = '0;
      for (int i = 0; i < DATA_W; i++) cw[DATA_POS[i]] = d[i];
      for (int k = 0; k < 4; k++) begin
         par = 1'b0;
         for (int p = 1; p < CODE_W; p++)
            if (p[k] && (p != (1 << k))) par = par ^ cw[p];
         cw[1 << k] = par;
      end
      cw[0] = ^cw[CODE_W-1:1];
      return cw;
   endfunction

   function automatic logic [3:0] syndrome(input logic [CODE_W-1:0] cw);
      logic [3:0] s;
      s = '0;
      for (int k = 0; k < 4; k++)
         for (int p = 1; p < CODE_W; p++)
            if (p[k]) s[k] = s[k] ^ cw[p];
      return s;
   endfunction

   function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] cw);
      logic [DATA_W-1:0] d;
      for (int i = 0; i < DATA_W; i++) d[i] = cw[DATA_POS[i]];
      return d;
   endfunction

endpackage

// File: rtl/secded_decoder.sv
// secded_decoder: combinational SEC-DED decode of one codeword.
//   cw     in  13  raw codeword from the array
//   data   out  8  data bits (corrected when correctable, raw otherwise)
//   cw_fix out 13  codeword with the single-bit error flipped back
//   status out  2  ST_CLEAN / ST_CORR / ST_UNCORR
module secded_decoder
   import secded_pkg::*;
(
   input  logic [CODE_W-1:0] cw,
   output logic [DATA_W-1:0] data,
   output logic [CODE_W-1:0] cw_fix,
   output status_e           status
);

   logic [3:0] s;
   logic       pe;

   always_comb begin
      s      = syndrome(cw);
      pe     = ^cw;
      cw_fix = cw;
      status = ST_CLEAN;
      if (pe) begin
         // A syndrome past position 12 cannot come from one flipped bit,
         // so it is reported as uncorrectable rather than guessed at.
         if (s < 4'd13) begin
            cw_fix[s] = ~cw[s];
            status    = ST_CORR;
         end else begin
            status    = ST_UNCORR;
         end
      end else if (s != 4'd0) begin
         status = ST_UNCORR;
      end
      data = extract(cw_fix);
   end

endmodule

// File: rtl/mem_secded_ctrl.sv
// mem_secded_ctrl: SEC-DED access controller with background scrubber.
//   clk, rst_n                    clock, async active-low reset
//   req_valid/ready/we/addr/wdata host request channel
//   rsp_valid/ready/rdata/status  host response channel
//   mem_wr_en/addr/wdata/rdata    codeword array port (combinational read)
//   corr_cnt, uncorr_cnt          saturating error counters
module mem_secded_ctrl
   import secded_pkg::*;
#(
   parameter int SCRUB_INTERVAL = 64,
   parameter int WRITEBACK      = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [3:0]        req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [1:0]        rsp_status,
   output logic              mem_wr_en,
   output logic [3:0]        mem_addr,
   output logic [CODE_W-1:0] mem_wdata,
   input  logic [CODE_W-1:0] mem_rdata,
   output logic [7:0]        corr_cnt,
   output logic [7:0]        uncorr_cnt
);

   ctrl_state_e       state;
   logic              scrub;       // current operation is a scrub, not a host op
   logic [3:0]        scrub_ptr;
   logic [31:0]       idle_cnt;
   logic [DATA_W-1:0] rd_data_q;
   logic [1:0]        rd_status_q;

   logic [DATA_W-1:0] dec_data;
   logic [CODE_W-1:0] dec_cw;
   status_e           dec_status;

   secded_decoder u_dec (
      .cw     (mem_rdata),
      .data   (dec_data),
      .cw_fix (dec_cw),
      .status (dec_status)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         req_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_status  <= ST_CLEAN;
         mem_wr_en   <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         corr_cnt    <= '0;
         uncorr_cnt  <= '0;
         scrub       <= 1'b0;
         scrub_ptr   <= '0;
         idle_cnt    <= '0;
         rd_data_q   <= '0;
         rd_status_q <= ST_CLEAN;
      end else begin
         case (state)
            IDLE: begin
               // Host request has priority over an expiring scrub timer.
               if (req_valid) begin
                  idle_cnt  <= '0;
                  req_ready <= 1'b0;
                  mem_addr  <= req_addr;
                  scrub     <= 1'b0;
                  if (req_we) begin
                     mem_wr_en <= 1'b1;
                     mem_wdata <= encode(req_wdata);
                     state     <= WR;
                  end else begin
                     state     <= RD;
                  end
               end else if (SCRUB_INTERVAL != 0) begin
                  if (idle_cnt == 32'(SCRUB_INTERVAL - 1)) begin
                     idle_cnt  <= '0;
                     req_ready <= 1'b0;
                     mem_addr  <= scrub_ptr;
                     scrub     <= 1'b1;
                     state     <= RD;
                  end else begin
                     idle_cnt  <= idle_cnt + 32'd1;
                  end
               end
            end
            WR: begin
               mem_wr_en  <= 1'b0;
               rsp_valid  <= 1'b1;
               rsp_rdata  <= '0;
               rsp_status <= ST_CLEAN;
               state      <= RSP;
            end
            RD: begin
               if (dec_status == ST_CORR && corr_cnt != 8'hFF)
                  corr_cnt <= corr_cnt + 8'd1;
               if (dec_status == ST_UNCORR && uncorr_cnt != 8'hFF)
                  uncorr_cnt <= uncorr_cnt + 8'd1;
               rd_data_q   <= dec_data;
               rd_status_q <= dec_status;
               // Scrubs always repair; host reads only when WRITEBACK is set.
               if (dec_status == ST_CORR && (scrub || WRITEBACK != 0)) begin
                  mem_wr_en <= 1'b1;
                  mem_wdata <= dec_cw;
                  state     <= WB;
               end else if (scrub) begin
                  scrub_ptr <= scrub_ptr + 4'd1;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end else begin
                  rsp_valid  <= 1'b1;
                  rsp_rdata  <= dec_data;
                  rsp_status <= dec_status;
                  state      <= RSP;
               end
            end
            WB: begin
               mem_wr_en <= 1'b0;
               if (scrub) begin
                  scrub_ptr <= scrub_ptr + 4'd1;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end else begin
                  rsp_valid  <= 1'b1;
                  rsp_rdata  <= rd_data_q;
                  rsp_status <= rd_status_q;
                  state      <= RSP;
               end
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               mem_wr_en <= 1'b0;
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_secded_ctrl.sv
// tb_mem_secded_ctrl: scoreboard bench for mem_secded_ctrl.
//   u_a: scrubbing off, WRITEBACK=1 -- host path, latency, saturation, reset abort.
//   u_b: SCRUB_INTERVAL=4, WRITEBACK=0 -- scrubber, pointer wrap, request priority.
module tb_mem_secded_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- instance A ----------------
   logic        a_rst_n, a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_mem_wr_en;
   logic [3:0]  a_req_addr, a_mem_addr;
   logic [7:0]  a_req_wdata, a_rsp_rdata, a_corr, a_uncorr;
   logic [1:0]  a_rsp_status;
   logic [12:0] a_mem_wdata, a_mem_rdata;
   logic [12:0] mem_a [16] = '{default: 13'h0};
   logic        a_pre_en = 1'b0;
   logic [3:0]  a_pre_addr = '0;
   logic [12:0] a_pre_data = '0;

   mem_secded_ctrl #(.SCRUB_INTERVAL(0), .WRITEBACK(1)) u_a (
      .clk(clk), .rst_n(a_rst_n),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
      .req_addr(a_req_addr), .req_wdata(a_req_wdata),
      .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
      .rsp_rdata(a_rsp_rdata), .rsp_status(a_rsp_status),
      .mem_wr_en(a_mem_wr_en), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
      .mem_rdata(a_mem_rdata), .corr_cnt(a_corr), .uncorr_cnt(a_uncorr)
   );

   assign a_mem_rdata = mem_a[a_mem_addr];
   always @(posedge clk) begin
      if (a_mem_wr_en) mem_a[a_mem_addr] <= a_mem_wdata;
      else if (a_pre_en) mem_a[a_pre_addr] <= a_pre_data;
   end

   // ---------------- instance B ----------------
   logic        b_rst_n, b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_mem_wr_en;
   logic [3:0]  b_req_addr, b_mem_addr;
   logic [7:0]  b_req_wdata, b_rsp_rdata, b_corr, b_uncorr;
   logic [1:0]  b_rsp_status;
   logic [12:0] b_mem_wdata, b_mem_rdata;
   logic [12:0] mem_b [16] = '{default: 13'h0};
   logic        b_pre_en = 1'b0;
   logic [3:0]  b_pre_addr = '0;
   logic [12:0] b_pre_data = '0;

   mem_secded_ctrl #(.SCRUB_INTERVAL(4), .WRITEBACK(0)) u_b (
      .clk(clk), .rst_n(b_rst_n),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
      .rsp_rdata(b_rsp_rdata), .rsp_status(b_rsp_status),
      .mem_wr_en(b_mem_wr_en), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_rdata(b_mem_rdata), .corr_cnt(b_corr), .uncorr_cnt(b_uncorr)
   );

   assign b_mem_rdata = mem_b[b_mem_addr];
   always @(posedge clk) begin
      if (b_mem_wr_en) mem_b[b_mem_addr] <= b_mem_wdata;
      else if (b_pre_en) mem_b[b_pre_addr] <= b_pre_data;
   end

   // ---------------- scoreboards ----------------
   logic [9:0]  exp_rsp_a [$];   // {rdata, status}
   logic [16:0] exp_wr_a  [$];   // {addr, codeword}
   logic [9:0]  exp_rsp_b [$];
   logic [16:0] exp_wr_b  [$];

   always @(negedge clk) begin
      logic [9:0]  er;
      logic [16:0] ew;
      if (a_rsp_valid && a_rsp_ready) begin
         if (exp_rsp_a.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL a_rsp_unexpected: got data 0x%0h status %0d, want no response", a_rsp_rdata, a_rsp_status);
         end else begin
            er = exp_rsp_a.pop_front();
            chk("a_rsp_rdata", {24'h0, a_rsp_rdata}, {24'h0, er[9:2]});
            chk("a_rsp_status", {30'h0, a_rsp_status}, {30'h0, er[1:0]});
         end
      end
      if (a_mem_wr_en) begin
         if (exp_wr_a.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL a_wr_unexpected: got addr %0d word 0x%0h, want no write", a_mem_addr, a_mem_wdata);
         end else begin
            ew = exp_wr_a.pop_front();
            chk("a_wr", {15'h0, a_mem_addr, a_mem_wdata}, {15'h0, ew});
         end
      end
      if (b_rsp_valid && b_rsp_ready) begin
         if (exp_rsp_b.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL b_rsp_unexpected: got data 0x%0h status %0d, want no response", b_rsp_rdata, b_rsp_status);
         end else begin
            er = exp_rsp_b.pop_front();
            chk("b_rsp_rdata", {24'h0, b_rsp_rdata}, {24'h0, er[9:2]});
            chk("b_rsp_status", {30'h0, b_rsp_status}, {30'h0, er[1:0]});
         end
      end
      if (b_mem_wr_en) begin
         if (exp_wr_b.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL b_wr_unexpected: got addr %0d word 0x%0h, want no write", b_mem_addr, b_mem_wdata);
         end else begin
            ew = exp_wr_b.pop_front();
            chk("b_wr", {15'h0, b_mem_addr, b_mem_wdata}, {15'h0, ew});
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic pre_a(input logic [3:0] ad, input logic [12:0] d);
      @(negedge clk); a_pre_en = 1'b1; a_pre_addr = ad; a_pre_data = d;
      @(posedge clk); #1 a_pre_en = 1'b0;
   endtask

   task automatic pre_b(input logic [3:0] ad, input logic [12:0] d);
      @(negedge clk); b_pre_en = 1'b1; b_pre_addr = ad; b_pre_data = d;
      @(posedge clk); #1 b_pre_en = 1'b0;
   endtask

   // One host op on A; lat = negedges from the handshake edge to rsp_valid.
   task automatic a_op(input logic we, input logic [3:0] ad, input logic [7:0] wd, input int lat);
      int n;
      @(negedge clk);
      n = 0;
      while (!a_req_ready && n < 20) begin @(negedge clk); n++; end
      chk("a_req_ready_wait", {31'h0, a_req_ready}, 32'h1);
      a_req_valid = 1'b1; a_req_we = we; a_req_addr = ad; a_req_wdata = wd;
      @(posedge clk); #1 a_req_valid = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!a_rsp_valid && n < 10);
      chk("a_latency", n, lat);
      @(posedge clk); #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n;
      a_rst_n = 1'b0; b_rst_n = 1'b0;
      a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = 1'b1;
      b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b1;

      pre_a(4'd5, 13'h002F);   // bit 5 flipped from data 0x01
      pre_a(4'd6, 13'h006F);   // bits 5 and 6 flipped
      pre_a(4'd7, 13'h002F);
      pre_b(4'd0, 13'h0001);   // overall parity bit flipped
      pre_b(4'd9, 13'h000F);   // clean data 0x01

      @(negedge clk);
      chk("rst_req_ready", {31'h0, a_req_ready}, 32'h1);
      chk("rst_rsp_valid", {31'h0, a_rsp_valid}, 32'h0);
      chk("rst_rsp_rdata", {24'h0, a_rsp_rdata}, 32'h0);
      chk("rst_rsp_status", {30'h0, a_rsp_status}, 32'h0);
      chk("rst_mem_wr_en", {31'h0, a_mem_wr_en}, 32'h0);
      chk("rst_mem_addr", {28'h0, a_mem_addr}, 32'h0);
      chk("rst_mem_wdata", {19'h0, a_mem_wdata}, 32'h0);
      chk("rst_corr_cnt", {24'h0, a_corr}, 32'h0);
      chk("rst_uncorr_cnt", {24'h0, a_uncorr}, 32'h0);
      chk("rst_b_req_ready", {31'h0, b_req_ready}, 32'h1);
      a_rst_n = 1'b1;

      // Write 0x01 @3 -> 0x000F; read it back clean.
      exp_wr_a.push_back({4'd3, 13'h000F}); exp_rsp_a.push_back({8'h00, 2'b00});
      a_op(1'b1, 4'd3, 8'h01, 2);
      exp_rsp_a.push_back({8'h01, 2'b00});
      a_op(1'b0, 4'd3, 8'h00, 2);

      // Single error @5: corrected, written back, one extra cycle.
      exp_wr_a.push_back({4'd5, 13'h000F}); exp_rsp_a.push_back({8'h01, 2'b01});
      a_op(1'b0, 4'd5, 8'h00, 3);
      chk("a_corr_cnt_1", {24'h0, a_corr}, 32'h1);
      exp_rsp_a.push_back({8'h01, 2'b00});
      a_op(1'b0, 4'd5, 8'h00, 2);

      // Double error @6: raw data bits d0..d2 set, no write-back.
      exp_rsp_a.push_back({8'h07, 2'b10});
      a_op(1'b0, 4'd6, 8'h00, 2);
      chk("a_uncorr_cnt_1", {24'h0, a_uncorr}, 32'h1);

      // 0xFF -> 0x1EEE, 0x00 -> 0x0000.
      exp_wr_a.push_back({4'd2, 13'h1EEE}); exp_rsp_a.push_back({8'h00, 2'b00});
      a_op(1'b1, 4'd2, 8'hFF, 2);
      exp_rsp_a.push_back({8'hFF, 2'b00});
      a_op(1'b0, 4'd2, 8'h00, 2);
      exp_wr_a.push_back({4'd4, 13'h0000}); exp_rsp_a.push_back({8'h00, 2'b00});
      a_op(1'b1, 4'd4, 8'h00, 2);

      // Saturation: 260 more uncorrectable reads.
      for (int i = 0; i < 260; i++) begin
         exp_rsp_a.push_back({8'h07, 2'b10});
         a_op(1'b0, 4'd6, 8'h00, 2);
      end
      chk("a_uncorr_sat", {24'h0, a_uncorr}, 32'hFF);
      chk("a_corr_hold", {24'h0, a_corr}, 32'h1);

      // Reset during WB of a corrected read of @7.
      exp_wr_a.push_back({4'd7, 13'h000F});
      @(negedge clk);
      a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 4'd7;
      @(posedge clk); #1 a_req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("a_wb_active", {31'h0, a_mem_wr_en}, 32'h1);
      #2 a_rst_n = 1'b0;
      #1;
      chk("abort_mem_wr_en", {31'h0, a_mem_wr_en}, 32'h0);
      chk("abort_rsp_valid", {31'h0, a_rsp_valid}, 32'h0);
      chk("abort_corr_cnt", {24'h0, a_corr}, 32'h0);
      chk("abort_uncorr_cnt", {24'h0, a_uncorr}, 32'h0);
      @(posedge clk);
      @(negedge clk);
      a_rst_n = 1'b1;
      chk("abort_no_write", {19'h0, mem_a[7]}, 32'h002F);
      chk("abort_req_ready", {31'h0, a_req_ready}, 32'h1);
      exp_wr_a.push_back({4'd7, 13'h000F}); exp_rsp_a.push_back({8'h01, 2'b01});
      a_op(1'b0, 4'd7, 8'h00, 3);
      chk("a_corr_after_rst", {24'h0, a_corr}, 32'h1);

      // ---------------- scrubber on B ----------------
      exp_wr_b.push_back({4'd0, 13'h0000});
      @(negedge clk);
      b_rst_n = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!b_mem_wr_en && n < 20);
      chk("b_scrub_wb_cycle", n, 5);
      @(negedge clk);
      chk("b_corr_cnt_1", {24'h0, b_corr}, 32'h1);
      chk("b_scrub_ptr_1", {28'h0, u_b.scrub_ptr}, 32'h1);
      repeat (80) @(negedge clk);
      chk("b_scrub_ptr_wrap", {28'h0, u_b.scrub_ptr}, 32'h1);
      chk("b_corr_cnt_hold", {24'h0, b_corr}, 32'h1);

      // Host request lands exactly on scrub expiry.
      n = 0;
      while (!(b_req_ready && u_b.idle_cnt == 32'd3) && n < 20) begin @(negedge clk); n++; end
      chk("b_expiry_found", {31'h0, b_req_ready}, 32'h1);
      exp_rsp_b.push_back({8'h01, 2'b00});
      b_rsp_ready = 1'b0;
      b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 4'd9;
      @(posedge clk); #1 b_req_valid = 1'b0;
      chk("b_req_taken", {28'h0, b_mem_addr}, 32'h9);
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("b_hold_valid", {31'h0, b_rsp_valid}, 32'h1);
         chk("b_hold_rdata", {24'h0, b_rsp_rdata}, 32'h01);
         chk("b_hold_status", {30'h0, b_rsp_status}, 32'h0);
         @(negedge clk);
      end
      b_rsp_ready = 1'b1;
      @(negedge clk);
      chk("b_ptr_no_scrub", {28'h0, u_b.scrub_ptr}, 32'h1);

      repeat (3) @(negedge clk);
      chk("q_rsp_a_empty", exp_rsp_a.size(), 0);
      chk("q_wr_a_empty", exp_wr_a.size(), 0);
      chk("q_rsp_b_empty", exp_rsp_b.size(), 0);
      chk("q_wr_b_empty", exp_wr_b.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_secded_ctrl.md
# mem_secded_ctrl

SEC-DED access controller that sits between the host and the 16-entry, 13-bit `mem_sec_ded` codeword array. It encodes host write data into Hamming(12,8)+overall-parity codewords. On reads, it decodes and corrects single-bit errors and flags double-bit errors. It also runs a background scrubber that rewrites corrected words and keeps saturating error counters.

## Interface

Parameters:
- `SCRUB_INTERVAL`, default 64: idle cycles between scrub operations; 0 disables scrubbing.
- `WRITEBACK`, default 1: when 1, a corrected host read is also written back to the array.

Ports:
- `clk`  in  1  clock. One clock domain; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  host request valid.
- `req_ready`  out  1  controller can accept a request.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  4  word address.
- `req_wdata`  in  8  write data.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  host accepts the response.
- `rsp_rdata`  out  8  read data after correction; 0 for writes.
- `rsp_status`  out  2  00 = clean, 01 = corrected, 10 = uncorrectable.
- `mem_wr_en`  out  1  array write enable.
- `mem_addr`  out  4  array address.
- `mem_wdata`  out  13  codeword to write.
- `mem_rdata`  in  13  codeword read combinationally at `mem_addr`.
- `corr_cnt`  out  8  corrected-error count, saturates at 255.
- `uncorr_cnt`  out  8  uncorrectable-error count, saturates at 255.

## Operation

Codeword format:
- Bit i, for i = 1..12, is Hamming position i.
- Check bits sit at positions 1, 2, 4 and 8.
- Data bits d0..d7 sit at positions 3, 5, 6, 7, 9, 10, 11, 12.
- Bit 0 is even parity over bits 1..12, so the whole 13-bit word has even parity.

Decode rules, with s = 4-bit syndrome and pe = overall parity mismatch:
- s = 0, pe = 0: clean.
- pe = 1: single error at position s (s = 0 means bit 0); flip that bit and report corrected.
- s != 0, pe = 0: double error; report uncorrectable and return the uncorrected data bits.

State machine: IDLE, WR, RD, WB, RSP.
- IDLE:
  - `req_ready` = 1 only in IDLE.
  - A handshake latches the address and write data.
  - A write goes to WR; a read goes to RD.
- WR:
  - Drive `mem_wr_en` = 1 with the encoded word for one cycle.
  - Go to RSP with status 00.
- RD:
  - Decode `mem_rdata` and register the data and status.
  - Update the error counters.
  - If the word was corrected and writeback applies, go to WB; otherwise go to RSP.
  - For a scrub operation with no writeback needed, return to IDLE.
- WB:
  - Drive `mem_wr_en` = 1 with the re-encoded corrected word for one cycle.
  - Go to RSP for a host read, or to IDLE for a scrub.
- RSP:
  - Hold `rsp_valid` = 1 and keep the data and status stable until `rsp_ready` is seen.
  - Then return to IDLE.

Scrubber:
- The idle counter increments each cycle the controller is in IDLE with `req_valid` = 0.
- When the counter reaches `SCRUB_INTERVAL`-1, a scrub of `scrub_ptr` starts: RD, then WB if correctable.
- A scrub always writes back corrected words, independent of `WRITEBACK`.
- Scrubs produce no response.
- `scrub_ptr` increments after each scrub and wraps from 15 to 0.
- The idle counter clears whenever the controller leaves IDLE.

Boundary rules:
- If `req_valid` and scrub expiry occur in the same cycle, the host request wins and the idle counter clears.
- Uncorrectable words are never written back.
- Counters stick at 255.
- Both host and scrub events are counted.

## Timing

Reset values:
- State is IDLE, so `req_ready` = 1.
- `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_status` = 00.
- `mem_wr_en` = 0, `mem_addr` = 0, `mem_wdata` = 0.
- Both counters = 0; `scrub_ptr` = 0; idle counter = 0.

Latency:
- Write: handshake in cycle 0, `mem_wr_en` in cycle 1, `rsp_valid` in cycle 2.
- Clean read: `rsp_valid` in cycle 2.
- Corrected read with `WRITEBACK` = 1: write-back in cycle 2, `rsp_valid` in cycle 3.

Other rules:
- `mem_addr` holds the latched address throughout RD, WR and WB.
- `mem_wr_en` is never asserted outside WR and WB.
- An `rst_n` assertion mid-operation aborts immediately: any pending write-back is dropped and `rsp_valid` falls asynchronously.
- The all-zero array contents after reset are valid codewords (data 0x00).

## Structure

- Package `secded_pkg` holds:
  - constants DATA_W = 8 and CODE_W = 13;
  - status codes ST_CLEAN, ST_CORR and ST_UNCORR;
  - the data-to-position map;
  - encode and syndrome functions.
- One combinational sub-module, `secded_decoder`: 13-bit codeword in; corrected data, corrected codeword and status out. It is shared between host reads and scrubs.
- The FSM, scrubber and counters live in `mem_secded_ctrl`.

## Test plan

- Write 0x01 to address 3: `mem_wdata` = 13'h000F for one cycle, then response status 00. Read address 3: `rsp_rdata` = 0x01, status 00.
- Preload address 5 with 13'h002F (bit 5 flipped), read it with `WRITEBACK` = 1: `rsp_rdata` = 0x01, status 01, write-back of 13'h000F, `corr_cnt` = 1, `rsp_valid` in cycle 3.
- Preload address 6 with 13'h006F (bits 5 and 6 flipped), read it: status 10, no `mem_wr_en`, `uncorr_cnt` = 1.
- `SCRUB_INTERVAL` = 4, address 0 holds 13'h0001 (bit 0 error), no requests: after 4 idle cycles a scrub writes 13'h0000 to address 0, `corr_cnt` = 1, `scrub_ptr` = 1; 16 more scrubs wrap the pointer back to 1.
- `req_valid` asserted in the scrub-expiry cycle: the host request is accepted and no scrub write occurs. Hold `rsp_ready` = 0 for 5 cycles: `rsp_valid` and data stay stable.
- Assert `rst_n` low during WB: `mem_wr_en` and `rsp_valid` drop to 0, counters clear, `req_ready` = 1 after release.
